// File: rtl/inst_mem_responder.sv
// Single-outstanding memory responder: accepts one read or byte-masked write,
// services it from a word array after LATENCY wait cycles, then holds the response.
module inst_mem_responder #(
  parameter int                    ADDR_WIDTH  = 32,
  parameter int                    DATA_WIDTH  = 32,
  parameter logic [ADDR_WIDTH-1:0] BASE_ADDR   = 32'h8000_0000,
  parameter int                    DEPTH_WORDS = 1024,
  parameter int                    LATENCY     = 2
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_req_valid,
  output logic                    o_req_ready,
  input  logic [ADDR_WIDTH-1:0]   i_req_addr,
  input  logic                    i_req_wen,
  input  logic [DATA_WIDTH-1:0]   i_req_wdata,
  input  logic [DATA_WIDTH/8-1:0] i_req_wmask,
  output logic                    o_resp_valid,
  input  logic                    i_resp_ready,
  output logic [DATA_WIDTH-1:0]   o_resp_rdata,
  output logic                    o_resp_err
);

  localparam int                    NLANES   = DATA_WIDTH / 8;
  localparam int                    IDX_W    = $clog2(DEPTH_WORDS);
  localparam logic [ADDR_WIDTH-1:0] SPAN     = ADDR_WIDTH'(4 * DEPTH_WORDS);
  localparam logic [3:0]            LAT_LOAD = 4'(LATENCY);

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_WAIT = 2'd1;
  localparam logic [1:0] S_RESP = 2'd2;

  logic [1:0]            r_state;
  logic [3:0]            r_cnt;
  logic                  r_req_ready;
  logic                  r_resp_valid;
  logic                  r_resp_err;
  logic [DATA_WIDTH-1:0] r_resp_rdata;
  logic [ADDR_WIDTH-1:0] r_addr;
  logic                  r_wen;
  logic [DATA_WIDTH-1:0] r_wdata;
  logic [NLANES-1:0]     r_wmask;
  logic [DATA_WIDTH-1:0] r_mem [DEPTH_WORDS];

  logic                  w_accept;
  logic                  w_commit;
  logic                  w_in_range;
  logic [ADDR_WIDTH-1:0] w_cmd_addr;
  logic                  w_cmd_wen;
  logic [DATA_WIDTH-1:0] w_cmd_wdata;
  logic [NLANES-1:0]     w_cmd_wmask;
  logic [ADDR_WIDTH-1:0] w_offset;
  logic [IDX_W-1:0]      w_idx;

  assign o_req_ready  = r_req_ready;
  assign o_resp_valid = r_resp_valid;
  assign o_resp_rdata = r_resp_rdata;
  assign o_resp_err   = r_resp_err;

  // With zero latency the access happens on the acceptance edge, so the command
  // comes straight from the request port; otherwise from the captured copy.
  always_comb begin
    w_accept    = r_req_ready & i_req_valid;
    w_cmd_addr  = (r_state == S_IDLE) ? i_req_addr  : r_addr;
    w_cmd_wen   = (r_state == S_IDLE) ? i_req_wen   : r_wen;
    w_cmd_wdata = (r_state == S_IDLE) ? i_req_wdata : r_wdata;
    w_cmd_wmask = (r_state == S_IDLE) ? i_req_wmask : r_wmask;
    // Unsigned subtraction wraps addresses below BASE_ADDR far above SPAN.
    w_offset    = w_cmd_addr - BASE_ADDR;
    w_in_range  = (w_offset < SPAN);
    w_idx       = w_offset[IDX_W+1:2];
    w_commit    = i_rst & (((LATENCY == 0) & w_accept) |
                           ((r_state == S_WAIT) & (r_cnt == 4'd1)));
  end

  always_ff @(posedge i_clk) begin
    if (w_commit && w_cmd_wen && w_in_range) begin
      for (int i = 0; i < NLANES; i++) begin
        if (w_cmd_wmask[i]) begin
          r_mem[w_idx][i*8 +: 8] <= w_cmd_wdata[i*8 +: 8];
        end
      end
    end
  end

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      r_state      <= S_IDLE;
      r_cnt        <= 4'd0;
      r_req_ready  <= 1'b0;
      r_resp_valid <= 1'b0;
      r_resp_err   <= 1'b0;
      r_resp_rdata <= '0;
      r_addr       <= '0;
      r_wen        <= 1'b0;
      r_wdata      <= '0;
      r_wmask      <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          r_req_ready <= 1'b1;
          if (w_accept) begin
            r_req_ready <= 1'b0;
            r_addr      <= i_req_addr;
            r_wen       <= i_req_wen;
            r_wdata     <= i_req_wdata;
            r_wmask     <= i_req_wmask;
            if (LATENCY == 0) begin
              r_state <= S_RESP;
            end else begin
              r_state <= S_WAIT;
              r_cnt   <= LAT_LOAD;
            end
          end
        end
        S_WAIT: begin
          r_cnt <= r_cnt - 4'd1;
          if (r_cnt == 4'd1) begin
            r_state <= S_RESP;
          end
        end
        S_RESP: begin
          if (r_resp_valid && i_resp_ready) begin
            r_resp_valid <= 1'b0;
            r_resp_rdata <= '0;
            r_resp_err   <= 1'b0;
            r_req_ready  <= 1'b1;
            r_state      <= S_IDLE;
          end
        end
        default: begin
          r_state <= S_IDLE;
        end
      endcase

      if (w_commit) begin
        r_resp_valid <= 1'b1;
        r_resp_err   <= ~w_in_range;
        r_resp_rdata <= (!w_cmd_wen && w_in_range) ? r_mem[w_idx] : '0;
      end
    end
  end

endmodule

// File: doc/inst_mem_responder.md
Name: inst_mem_responder

Overview:
- Memory-side responder for the core's instruction/data memory port.
- Accepts one request at a time (read or byte-masked write) over a valid/ready request channel.
- Services the request from an internal word array after a programmable latency, then returns the result on a valid/ready response channel.
- Used as the simulation/FPGA backing memory behind the core's fetch and load/store ports, and as the reference slave for bus bring-up.

Parameters:
- ADDR_WIDTH, 32, request address width in bits.
- DATA_WIDTH, 32, data width in bits; fixed at 32 (4 byte lanes).
- BASE_ADDR, 32'h80000000, first byte address mapped to word 0 (reset PC of the core).
- DEPTH_WORDS, 1024, number of 32-bit words in storage; must be a power of two.
- LATENCY, 2, extra wait cycles between request acceptance and the response; legal range 0..15.

Ports:
- clk  in  1  clock; all state changes on the rising edge.
- rst  in  1  asynchronous, active-low reset.
- req_valid  in  1  request present.
- req_ready  out  1  responder can accept a request.
- req_addr  in  32  byte address; bits [1:0] are ignored (word access).
- req_wen  in  1  1 = write, 0 = read.
- req_wdata  in  32  write data.
- req_wmask  in  4  byte enables for writes; bit i enables byte lane i.
- resp_valid  out  1  response present.
- resp_ready  in  1  requester accepts the response.
- resp_rdata  out  32  read data; 0 for writes and for errors.
- resp_err  out  1  address outside [BASE_ADDR, BASE_ADDR + 4*DEPTH_WORDS).

Behaviour:
- Reset (rst = 0, asynchronous): state is IDLE; outputs req_ready = 0 while rst is asserted and 1 from the first edge after release; resp_valid = 0, resp_rdata = 0, resp_err = 0; wait counter = 0. Storage contents are not reset.
- Reset asserted during WAIT or RESP: the pending request is abandoned. A pending write that has not yet been committed is never performed. Any response not yet handshaken is dropped.
- FSM states IDLE, WAIT, RESP. req_ready = 1 only in IDLE.
- IDLE: when req_valid & req_ready, capture addr, wen, wdata and wmask.
  - LATENCY = 0: go to RESP.
  - Otherwise: go to WAIT with counter = LATENCY.
- WAIT: decrement the counter each cycle; when counter == 1, go to RESP on the next edge.
- Entry to RESP (the same edge that sets resp_valid):
  - Read: resp_rdata = mem[index].
  - Write: each lane with wmask[i] = 1 is updated; resp_rdata = 0.
  - index = (addr - BASE_ADDR) >> 2.
- Latency: resp_valid is first high exactly LATENCY + 1 cycles after the acceptance edge.
- RESP: resp_valid, resp_rdata and resp_err are held stable until resp_valid & resp_ready.
  - On that edge: resp_valid drops to 0, resp_rdata clears to 0, and state returns to IDLE.
- Throughput: at most one request per LATENCY + 2 cycles. There are no outstanding-request queues.
- Out of range: resp_err = 1 and resp_rdata = 0; writes are discarded with no storage change. Address arithmetic is 32-bit unsigned; addresses below BASE_ADDR are out of range, with no wrap into the array.
- Write with wmask = 0: a legal no-op write. It still produces a response with resp_err = 0.
- Read-after-write: a read accepted after a write's response observes the written data.
- Inputs are sampled only on the acceptance edge; changes to req_* while not in IDLE are ignored.

Test Plan:
- Reset, then write 32'hDEADBEEF to 32'h80000000 (wmask 4'hF, LATENCY 2), then read the same address -> resp_valid rises 3 cycles after each acceptance; the read returns 32'hDEADBEEF with resp_err = 0.
- Partial write of 32'h000000AA with wmask 4'b0001 over word 32'h11223344 at 32'h80000010, then read -> 32'h112233AA.
- Read 32'h7FFFFFFC and read BASE_ADDR + 4*DEPTH_WORDS -> resp_err = 1, resp_rdata = 0. A write to 32'h80001000 followed by a read of 32'h80000000 shows word 0 unchanged.
- Hold resp_ready = 0 for 5 cycles after resp_valid -> resp_valid, resp_rdata and resp_err stay constant and req_ready stays 0; raising resp_ready returns the block to IDLE with req_ready = 1 on the next cycle.
- Build with LATENCY = 0 and issue back-to-back reads with resp_ready tied to 1 -> each response appears 1 cycle after acceptance; a new request is accepted every 2 cycles.
- Assert rst during WAIT of a write of 32'h55 to 32'h80000020 -> outputs clear immediately; a later read of that address returns the previous contents, not 32'h55.
